// File: rtl/dpram_orig.sv
// True dual-port synchronous RAM, one clock, raw-bit storage for the operand buffers.
// Optional macro DPRAM_ORIG_ZERO_INIT_EN: array starts all-zero instead of undefined.

// Purpose: two independent read/write ports onto a shared NUM_WORDS x DWIDTH array.
// Latency: 1 cycle read (read-old-data), new write data readable from the next edge.
// Backpressure: none; every edge is an access on each port.
module dpram_orig #(
  parameter int AWIDTH    = 10,
  parameter int DWIDTH    = 16,
  parameter int NUM_WORDS = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [AWIDTH-1:0] address_a,
  input  logic              wren_a,
  input  logic [DWIDTH-1:0] data_a,
  output logic [DWIDTH-1:0] out_a,
  input  logic [AWIDTH-1:0] address_b,
  input  logic              wren_b,
  input  logic [DWIDTH-1:0] data_b,
  output logic [DWIDTH-1:0] out_b
);

  localparam logic [AWIDTH:0] DEPTH = NUM_WORDS[AWIDTH:0];

`ifdef DPRAM_ORIG_ZERO_INIT_EN
  logic [DWIDTH-1:0] mem [NUM_WORDS] = '{default: '0};
`else
  logic [DWIDTH-1:0] mem [NUM_WORDS];
`endif

  logic in_range_a;
  logic in_range_b;

  assign in_range_a = ({1'b0, address_a} < DEPTH);
  assign in_range_b = ({1'b0, address_b} < DEPTH);

  // Port B's write is issued last so it wins a same-address collision.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (wren_a && in_range_a) mem[address_a] <= data_a;
      if (wren_b && in_range_b) mem[address_b] <= data_b;
    end
  end

  // Nonblocking reads sample the array before this edge's writes land.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_a <= '0;
      out_b <= '0;
    end else begin
      if (!wren_a) out_a <= in_range_a ? mem[address_a] : '0;
      if (!wren_b) out_b <= in_range_b ? mem[address_b] : '0;
    end
  end

endmodule

// File: tb/tb_dpram_orig.sv
// Directed plus randomized checks of dpram_orig against an array-based reference model.
module tb_dpram_orig;
  localparam int AW = 10;
  localparam int DW = 8;
  localparam int NW = 1000;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] address_a, address_b;
  logic          wren_a, wren_b;
  logic [DW-1:0] data_a, data_b;
  logic [DW-1:0] out_a, out_b;

  logic [DW-1:0] model [NW];
  logic [DW-1:0] exp_a, exp_b;
  int vectors = 0;
  int miscompares = 0;

  dpram_orig #(.AWIDTH(AW), .DWIDTH(DW), .NUM_WORDS(NW)) dut (
    .clk(clk), .reset(reset),
    .address_a(address_a), .wren_a(wren_a), .data_a(data_a), .out_a(out_a),
    .address_b(address_b), .wren_b(wren_b), .data_b(data_b), .out_b(out_b)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] want);
    vectors++;
    assert (got === want) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, got, want);
    end
  endtask

  // One clock edge: drive both ports, advance the model, compare both outputs.
  task automatic step(input string tag,
                      input logic [AW-1:0] aa, input logic wa, input logic [DW-1:0] da,
                      input logic [AW-1:0] ab, input logic wb, input logic [DW-1:0] db,
                      input logic rst);
    @(negedge clk);
    reset = rst;
    address_a = aa; wren_a = wa; data_a = da;
    address_b = ab; wren_b = wb; data_b = db;
    if (rst) begin
      exp_a = '0;
      exp_b = '0;
    end else begin
      if (!wa) exp_a = (int'(aa) < NW) ? model[int'(aa)] : '0;
      if (!wb) exp_b = (int'(ab) < NW) ? model[int'(ab)] : '0;
      if (wa && int'(aa) < NW) model[int'(aa)] = da;
      if (wb && int'(ab) < NW) model[int'(ab)] = db;
    end
    @(posedge clk);
    #1;
    check({tag, "_a"}, out_a, exp_a);
    check({tag, "_b"}, out_b, exp_b);
  endtask

  initial begin
    logic [DW-1:0] old_word;
    reset = 1'b1;
    address_a = '0; wren_a = 1'b0; data_a = '0;
    address_b = '0; wren_b = 1'b0; data_b = '0;

    step("reset", 10'd0, 1'b0, 8'h00, 10'd0, 1'b0, 8'h00, 1'b1);
    check("reset_out_a", out_a, 8'h00);
    check("reset_out_b", out_b, 8'h00);

    // Fill every word so no later read touches undefined contents.
    for (int i = 0; i < NW / 2; i++)
      step("fill", AW'(i), 1'b1, DW'($urandom), AW'(i + NW / 2), 1'b1, DW'($urandom), 1'b0);

    step("a_wr", 10'h005, 1'b1, 8'h14, 10'h100, 1'b0, 8'h00, 1'b0);
    step("a_rd", 10'h005, 1'b0, 8'h00, 10'h100, 1'b0, 8'h00, 1'b0);
    check("a_rd_const", out_a, 8'h14);

    step("b_wr", 10'h101, 1'b0, 8'h00, 10'h00A, 1'b1, 8'hFC, 1'b0);
    step("b_rd", 10'h101, 1'b0, 8'h00, 10'h00A, 1'b0, 8'h00, 1'b0);
    check("b_rd_const", out_b, 8'hFC);

    // Same-edge cross-port read sees the old word, next edge sees the new one.
    old_word = model[21];
    step("xwr", 10'h015, 1'b1, 8'h19, 10'h015, 1'b0, 8'h00, 1'b0);
    check("xport_old", out_b, old_word);
    step("xrd", 10'h000, 1'b0, 8'h00, 10'h015, 1'b0, 8'h00, 1'b0);
    check("xport_new", out_b, 8'h19);

    step("dual_wr", 10'h020, 1'b1, 8'h08, 10'h021, 1'b1, 8'h0C, 1'b0);
    step("dual_rd", 10'h020, 1'b0, 8'h00, 10'h021, 1'b0, 8'h00, 1'b0);
    check("dual_a", out_a, 8'h08);
    check("dual_b", out_b, 8'h0C);

    step("coll_wr", 10'h030, 1'b1, 8'h20, 10'h030, 1'b1, 8'h28, 1'b0);
    step("coll_rd", 10'h030, 1'b0, 8'h00, 10'h030, 1'b0, 8'h00, 1'b0);
    check("coll_a", out_a, 8'h28);
    check("coll_b", out_b, 8'h28);

    // Out-of-range writes vanish and reads return zero.
    step("oor_wr", 10'd1010, 1'b1, 8'hAA, 10'd1023, 1'b1, 8'h55, 1'b0);
    step("oor_rd", 10'd1010, 1'b0, 8'h00, 10'd1023, 1'b0, 8'h00, 1'b0);
    check("oor_a", out_a, 8'h00);
    check("oor_b", out_b, 8'h00);

    // A reset edge drops the write and clears outputs, contents survive.
    old_word = model[64];
    step("rst_wr", 10'h040, 1'b1, 8'hEE, 10'h030, 1'b0, 8'h00, 1'b1);
    step("rst_rd", 10'h040, 1'b0, 8'h00, 10'h030, 1'b0, 8'h00, 1'b0);
    check("rst_kept", out_a, old_word);
    check("rst_kept_b", out_b, 8'h28);

    for (int i = 0; i < 400; i++)
      step("rand",
           AW'($urandom_range(0, 1023)), 1'($urandom_range(0, 1)), DW'($urandom),
           AW'(($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 1023)),
           1'($urandom_range(0, 1)), DW'($urandom),
           1'($urandom_range(0, 39) == 0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
